// File: rtl/td4_ctrl_pkg.sv
// Shared mode encodings and default widths for the TD4 run/step controller.
package td4_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2,
        MODE_BRK  = 2'd3
    } mode_e;

    localparam int TD4_DIV_W = 24;
    localparam int TD4_PC_W  = 8;
    localparam int TD4_CNT_W = 16;

endpackage

// File: rtl/td4_btn_debounce.sv
// Raw button -> 2-flop synchronizer -> debounce counter -> one-cycle press pulse.
module td4_btn_debounce #(
    parameter int DBNC_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW       = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          level_dly_q;
    logic          press_q;

    // Level rises on the DBNC_CYCLES-th consecutive high sample, drops on any low one.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (!sync2_q) begin
            cnt_d   = '0;
            level_d = 1'b0;
        end else if (!level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/td4_run_ctrl.sv
// Run/step controller producing the TD4 core clock-enable strobe.
// Define TD4_RUN_AUTOSTART_EN to come out of reset free-running (mode RUN).
module td4_run_ctrl
    import td4_ctrl_pkg::*;
#(
    parameter int DIV_W       = TD4_DIV_W,
    parameter int DBNC_CYCLES = 50000,
    parameter int PC_W        = TD4_PC_W,
    parameter int CNT_W       = TD4_CNT_W
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] div_limit,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             cpu_step,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_cnt
);

`ifdef TD4_RUN_AUTOSTART_EN
    localparam mode_e RESET_MODE = MODE_RUN;
`else
    localparam mode_e RESET_MODE = MODE_HALT;
`endif

    mode_e            mode_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             bp_skip_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             run_press;
    logic             step_press;
    logic             bp_hit;
    logic             div_term;

    td4_btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) u_run_dbnc (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .btn_i   (run_btn),
        .press_o (run_press)
    );

    td4_btn_debounce #(.DBNC_CYCLES(DBNC_CYCLES)) u_step_dbnc (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .btn_i   (step_btn),
        .press_o (step_press)
    );

    // bp_skip masks the breakpoint so a resume can execute the instruction at bp_addr.
    assign bp_hit   = bp_en & (cpu_pc == bp_addr) & ~bp_skip_q;
    assign div_term = (div_cnt_q >= div_limit);

    always_comb begin
        cpu_step = 1'b0;
        if (!RESET) begin
            case (mode_q)
                MODE_STEP: cpu_step = 1'b1;
                MODE_RUN:  cpu_step = ~run_press & div_term & ~bp_hit;
                default:   cpu_step = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            mode_q     <= RESET_MODE;
            div_cnt_q  <= '0;
            bp_skip_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            if (cpu_step) begin
                step_cnt_q <= step_cnt_q + 1'b1;
                bp_skip_q  <= 1'b0;
            end
            case (mode_q)
                MODE_HALT: begin
                    if (run_press) begin
                        mode_q    <= MODE_RUN;
                        div_cnt_q <= '0;
                    end else if (step_press) begin
                        mode_q <= MODE_STEP;
                    end
                end
                MODE_RUN: begin
                    if (run_press) begin
                        mode_q <= MODE_HALT;
                    end else if (div_term) begin
                        div_cnt_q <= '0;
                        if (bp_hit) begin
                            mode_q <= MODE_BRK;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                MODE_STEP: begin
                    mode_q <= MODE_HALT;
                end
                MODE_BRK: begin
                    if (run_press) begin
                        mode_q    <= MODE_RUN;
                        div_cnt_q <= '0;
                        bp_skip_q <= 1'b1;
                    end else if (step_press) begin
                        mode_q    <= MODE_STEP;
                        bp_skip_q <= 1'b1;
                    end
                end
                default: begin
                    mode_q <= RESET_MODE;
                end
            endcase
        end
    end

    assign mode     = mode_q;
    assign step_cnt = step_cnt_q;

endmodule
